// File: rtl/json_stream_checker.sv
// Streaming JSON well-formedness checker: one byte per cycle in, one result per document out.
// Reports OK or the first error code with the byte offset, plus the deepest nesting reached.
module json_stream_checker #(
  parameter int unsigned MAX_DEPTH = 16,
  parameter int unsigned POS_W = 32,
  localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_ok,
  output logic [3:0]         res_err,
  output logic [POS_W-1:0]   res_pos,
  output logic [DEPTH_W-1:0] res_max_depth
);

  localparam int unsigned STACK_N = 1 << DEPTH_W;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

  localparam logic [3:0] ERR_NONE  = 4'd0;
  localparam logic [3:0] ERR_CHAR  = 4'd1;
  localparam logic [3:0] ERR_BRKT  = 4'd2;
  localparam logic [3:0] ERR_DEPTH = 4'd3;
  localparam logic [3:0] ERR_ESC   = 4'd4;
  localparam logic [3:0] ERR_LIT   = 4'd5;
  localparam logic [3:0] ERR_END   = 4'd6;
  localparam logic [3:0] ERR_TRAIL = 4'd7;
  localparam logic [3:0] ERR_CTRL  = 4'd8;

  localparam logic [1:0] LIT_TRUE  = 2'd0;
  localparam logic [1:0] LIT_FALSE = 2'd1;
  localparam logic [1:0] LIT_NULL  = 2'd2;

  typedef enum logic [2:0] {
    S_VALUE, S_STR, S_ESC, S_UHEX, S_LIT, S_NUM, S_AFTER, S_DRAIN
  } state_t;

  state_t               state_q, state_d, eff_state;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [STACK_N-1:0]   stack_q, stack_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [1:0]           lit_sel_q, lit_sel_d;
  logic [2:0]           lit_idx_q, lit_idx_d;
  logic [1:0]           hex_cnt_q, hex_cnt_d;
  logic [3:0]           err_q, err_d;
  logic [POS_W-1:0]     err_pos_q, err_pos_d;
  logic [DEPTH_W-1:0]   max_q, max_d;
  logic                 res_valid_d, res_ok_d, in_ready_d;
  logic [3:0]           res_err_d, byte_err, fin_err;
  logic [POS_W-1:0]     res_pos_d, fin_pos;
  logic [DEPTH_W-1:0]   res_max_depth_d;
  logic                 accept, incomplete;

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  function automatic logic is_delim(input logic [7:0] c);
    return is_ws(c) || (c == ",") || (c == "]") || (c == "}");
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return is_digit(c) || ((c >= "a") && (c <= "f")) || ((c >= "A") && (c <= "F"));
  endfunction

  function automatic logic [2:0] lit_len(input logic [1:0] sel);
    return (sel == LIT_FALSE) ? 3'd5 : 3'd4;
  endfunction

  // Expected character at position idx of "true" / "false" / "null".
  function automatic logic [7:0] lit_char(input logic [1:0] sel, input logic [2:0] idx);
    logic [7:0] c;
    c = 8'h00;
    case (sel)
      LIT_TRUE: begin
        case (idx)
          3'd1: c = "r";
          3'd2: c = "u";
          3'd3: c = "e";
          default: c = 8'h00;
        endcase
      end
      LIT_FALSE: begin
        case (idx)
          3'd1: c = "a";
          3'd2: c = "l";
          3'd3: c = "s";
          3'd4: c = "e";
          default: c = 8'h00;
        endcase
      end
      default: begin
        case (idx)
          3'd1: c = "u";
          3'd2: c = "l";
          3'd3: c = "l";
          default: c = 8'h00;
        endcase
      end
    endcase
    return c;
  endfunction

  always_comb begin
    state_d         = state_q;
    depth_d         = depth_q;
    stack_d         = stack_q;
    pos_d           = pos_q;
    lit_sel_d       = lit_sel_q;
    lit_idx_d       = lit_idx_q;
    hex_cnt_d       = hex_cnt_q;
    err_d           = err_q;
    err_pos_d       = err_pos_q;
    max_d           = max_q;
    res_valid_d     = res_valid;
    res_ok_d        = res_ok;
    res_err_d       = res_err;
    res_pos_d       = res_pos;
    res_max_depth_d = res_max_depth;
    byte_err        = ERR_NONE;
    fin_err         = ERR_NONE;
    fin_pos         = '0;
    incomplete      = 1'b0;
    eff_state       = state_q;
    accept          = in_valid && in_ready;

    if (res_valid && res_ready) res_valid_d = 1'b0;

    if (accept) begin
      pos_d = (&pos_q) ? pos_q : pos_q + POS_W'(1);

      // A delimiter closes a finished literal or number and is then handled as a fresh byte.
      if (((state_q == S_NUM) || ((state_q == S_LIT) && (lit_idx_q == lit_len(lit_sel_q))))
          && is_delim(in_data))
        eff_state = (depth_q == '0) ? S_AFTER : S_VALUE;
      state_d = eff_state;

      case (eff_state)
        S_VALUE: begin
          if (is_ws(in_data)) begin
            state_d = S_VALUE;
          end else if ((in_data == "{") || (in_data == "[")) begin
            if (depth_q == DEPTH_MAX) begin
              byte_err = ERR_DEPTH;
            end else begin
              stack_d[depth_q] = (in_data == "{");
              depth_d = depth_q + DEPTH_W'(1);
              if (depth_d > max_q) max_d = depth_d;
            end
          end else if ((in_data == "}") || (in_data == "]")) begin
            if ((depth_q == '0) || (stack_q[depth_q - DEPTH_W'(1)] != (in_data == "}"))) begin
              byte_err = ERR_BRKT;
            end else begin
              depth_d = depth_q - DEPTH_W'(1);
              state_d = (depth_d == '0) ? S_AFTER : S_VALUE;
            end
          end else if (in_data == "\"") begin
            state_d = S_STR;
          end else if ((in_data == "t") || (in_data == "f") || (in_data == "n")) begin
            state_d   = S_LIT;
            lit_idx_d = 3'd1;
            lit_sel_d = (in_data == "t") ? LIT_TRUE : ((in_data == "f") ? LIT_FALSE : LIT_NULL);
          end else if ((in_data == "-") || is_digit(in_data)) begin
            state_d = S_NUM;
          end else if ((in_data == ",") || (in_data == ":")) begin
            if (depth_q == '0) byte_err = ERR_CHAR;
          end else begin
            byte_err = ERR_CHAR;
          end
        end
        S_STR: begin
          if (in_data == "\"")      state_d = (depth_q == '0) ? S_AFTER : S_VALUE;
          else if (in_data == "\\") state_d = S_ESC;
          else if (in_data < 8'h20) byte_err = ERR_CTRL;
        end
        S_ESC: begin
          if ((in_data == "\"") || (in_data == "\\") || (in_data == "/") || (in_data == "b") ||
              (in_data == "f") || (in_data == "n") || (in_data == "r") || (in_data == "t")) begin
            state_d = S_STR;
          end else if (in_data == "u") begin
            state_d   = S_UHEX;
            hex_cnt_d = 2'd0;
          end else begin
            byte_err = ERR_ESC;
          end
        end
        S_UHEX: begin
          if (!is_hex(in_data))      byte_err = ERR_ESC;
          else if (hex_cnt_q == 2'd3) state_d = S_STR;
          else                        hex_cnt_d = hex_cnt_q + 2'd1;
        end
        S_LIT: begin
          if ((lit_idx_q != lit_len(lit_sel_q)) && (in_data == lit_char(lit_sel_q, lit_idx_q)))
            lit_idx_d = lit_idx_q + 3'd1;
          else
            byte_err = ERR_LIT;
        end
        S_NUM: begin
          if (!(is_digit(in_data) || (in_data == ".") || (in_data == "e") || (in_data == "E") ||
                (in_data == "+") || (in_data == "-")))
            byte_err = ERR_CHAR;
        end
        S_AFTER: begin
          if (!is_ws(in_data)) byte_err = ERR_TRAIL;
        end
        default: begin
          state_d = S_DRAIN;
        end
      endcase

      if (byte_err != ERR_NONE) begin
        err_d     = byte_err;
        err_pos_d = pos_q;
        state_d   = S_DRAIN;
      end

      // Close out the document and re-arm for the next one.
      if (in_last) begin
        incomplete = (state_d inside {S_STR, S_ESC, S_UHEX}) || (depth_d != '0) ||
                     ((state_d == S_LIT) && (lit_idx_d != lit_len(lit_sel_d))) ||
                     (state_d == S_VALUE);
        fin_err = err_d;
        fin_pos = err_pos_d;
        if ((err_d == ERR_NONE) && incomplete) begin
          fin_err = ERR_END;
          fin_pos = pos_d;
        end
        res_valid_d     = 1'b1;
        res_ok_d        = (fin_err == ERR_NONE);
        res_err_d       = fin_err;
        res_pos_d       = (fin_err == ERR_NONE) ? '0 : fin_pos;
        res_max_depth_d = max_d;
        state_d         = S_VALUE;
        depth_d         = '0;
        pos_d           = '0;
        max_d           = '0;
        err_d           = ERR_NONE;
        err_pos_d       = '0;
      end
    end

    in_ready_d = !res_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_VALUE;
      depth_q       <= '0;
      stack_q       <= '0;
      pos_q         <= '0;
      lit_sel_q     <= LIT_TRUE;
      lit_idx_q     <= '0;
      hex_cnt_q     <= '0;
      err_q         <= ERR_NONE;
      err_pos_q     <= '0;
      max_q         <= '0;
      in_ready      <= 1'b1;
      res_valid     <= 1'b0;
      res_ok        <= 1'b0;
      res_err       <= ERR_NONE;
      res_pos       <= '0;
      res_max_depth <= '0;
    end else begin
      state_q       <= state_d;
      depth_q       <= depth_d;
      stack_q       <= stack_d;
      pos_q         <= pos_d;
      lit_sel_q     <= lit_sel_d;
      lit_idx_q     <= lit_idx_d;
      hex_cnt_q     <= hex_cnt_d;
      err_q         <= err_d;
      err_pos_q     <= err_pos_d;
      max_q         <= max_d;
      in_ready      <= in_ready_d;
      res_valid     <= res_valid_d;
      res_ok        <= res_ok_d;
      res_err       <= res_err_d;
      res_pos       <= res_pos_d;
      res_max_depth <= res_max_depth_d;
    end
  end

endmodule

// File: tb/tb_json_stream_checker.sv
// Directed bench for json_stream_checker: table of documents with hand-computed results,
// plus back-pressure and mid-document reset sequences.
module tb_json_stream_checker;

  localparam int unsigned MAX_DEPTH = 4;
  localparam int unsigned POS_W = 5;
  localparam int unsigned DEPTH_W = 3;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               res_valid;
  logic               res_ready;
  logic               res_ok;
  logic [3:0]         res_err;
  logic [POS_W-1:0]   res_pos;
  logic [DEPTH_W-1:0] res_max_depth;

  json_stream_checker #(.MAX_DEPTH(MAX_DEPTH), .POS_W(POS_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok), .res_err(res_err),
    .res_pos(res_pos), .res_max_depth(res_max_depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string doc;
    int    ok;
    int    err;
    int    pos;
    int    maxd;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input string d, input int ok, input int err, input int pos,
                              input int maxd);
    vec_t v;
    v.doc = d; v.ok = ok; v.err = err; v.pos = pos; v.maxd = maxd;
    vecs.push_back(v);
  endfunction

  // Drive one byte per cycle at the falling edge; returns at the negedge after the last accept.
  task automatic send_doc(input string s, input bit with_last);
    int n;
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 50) begin
        in_valid = 1'b0;
        @(negedge clk);
        n++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = with_last && (i == s.len() - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string nm, input int ok, input int err, input int pos,
                              input int maxd);
    chk({nm, ".valid"}, int'(res_valid), 1);
    chk({nm, ".ok"},    int'(res_ok), ok);
    chk({nm, ".err"},   int'(res_err), err);
    chk({nm, ".pos"},   int'(res_pos), pos);
    chk({nm, ".maxd"},  int'(res_max_depth), maxd);
  endtask

  task automatic consume(input string nm);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({nm, ".valid_clr"}, int'(res_valid), 0);
    chk({nm, ".ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    string sp;
    bit    rose;
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", int'(in_ready), 1);
    chk("rst.res_valid", int'(res_valid), 0);
    chk("rst.res_ok", int'(res_ok), 0);
    chk("rst.res_err", int'(res_err), 0);
    chk("rst.res_pos", int'(res_pos), 0);
    chk("rst.res_max_depth", int'(res_max_depth), 0);
    rst_n = 1'b1;
    @(negedge clk);

    sp = "";
    for (int i = 0; i < 40; i++) sp = {sp, " "};

    //  document                   ok err pos maxd
    add("{\"a\":[1,true,null]}",    1, 0, 0, 2);
    add("[1,2}",                    0, 2, 4, 1);
    add("]",                        0, 2, 0, 0);
    add("[[[[[]]]]]",               0, 3, 4, 4);
    add("\"\\q\"",                  0, 4, 2, 0);
    add("\"\\u12G4\"",              0, 4, 5, 0);
    add("\"a\n\"",                  0, 8, 2, 0);
    add("[tru]",                    0, 5, 4, 1);
    add("{\"a\":1} x",              0, 7, 8, 1);
    add("[\"abc",                   0, 6, 5, 1);
    add("-12",                      1, 0, 0, 0);
    add("true",                     1, 0, 0, 0);
    add("nul",                      0, 6, 3, 0);
    add("  ",                       0, 6, 2, 0);
    add("truex",                    0, 5, 4, 0);
    add("[1]]",                     0, 7, 3, 1);
    add("\"\\u00aF\"",              1, 0, 0, 0);
    add(",",                        0, 1, 0, 0);
    add("@",                        0, 1, 0, 0);
    add("{\"k\" : [ ] }\t",         1, 0, 0, 2);
    add("[[",                       0, 6, 2, 2);
    add("[x",                       0, 1, 1, 1);
    add("[true ,false]",            1, 0, 0, 1);
    add("1,",                       0, 7, 1, 0);
    add(sp,                         0, 6, 31, 0);
    add({sp, "x"},                  0, 1, 31, 0);

    foreach (vecs[k]) begin
      send_doc(vecs[k].doc, 1'b1);
      check_result($sformatf("v%0d", k), vecs[k].ok, vecs[k].err, vecs[k].pos, vecs[k].maxd);
      consume($sformatf("v%0d", k));
    end

    // Back-pressure: result held for 5 cycles while a byte waits on the input.
    send_doc("[1]", 1'b1);
    in_valid = 1'b1; in_data = "x"; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d.in_ready", c), int'(in_ready), 0);
      chk($sformatf("hold%0d.valid", c), int'(res_valid), 1);
      chk($sformatf("hold%0d.ok", c), int'(res_ok), 1);
      chk($sformatf("hold%0d.maxd", c), int'(res_max_depth), 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume("hold");
    send_doc("7", 1'b1);
    check_result("after_hold", 1, 0, 0, 0);
    consume("after_hold");

    // Reset mid-document: no result, outputs back to reset values, state re-armed.
    send_doc("[[1,", 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", int'(in_ready), 1);
    chk("midrst.res_valid", int'(res_valid), 0);
    chk("midrst.res_ok", int'(res_ok), 0);
    chk("midrst.res_err", int'(res_err), 0);
    chk("midrst.res_pos", int'(res_pos), 0);
    chk("midrst.res_max_depth", int'(res_max_depth), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rose = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (res_valid) rose = 1'b1;
    end
    chk("midrst.no_result", int'(rose), 0);
    send_doc("[]", 1'b1);
    check_result("post_rst", 1, 0, 0, 1);
    consume("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/json_stream_checker.md
Name: json_stream_checker

Overview:
- Streaming hardware JSON well-formedness checker. Consumes one document as a byte stream (valid/ready, `last` on the final byte) and returns one result per document: OK or first error code plus byte position.
- Gives the on-chip equivalent of the load-and-expect-OK checks the testbench applies to JSON strings and files.
- Generalised over nesting depth and position-counter width, with a result handshake so results can back-pressure the stream.

Parameters:
- MAX_DEPTH, 16: maximum nesting depth of objects/arrays. Must be ≥1.
- POS_W, 32: width of the byte-position counter. The counter saturates at all-ones.
- DEPTH_W, $clog2(MAX_DEPTH+1): derived localparam, not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid&in_ready
- in_data  in  8  byte
- in_last  in  1  final byte of document
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid&res_ready
- res_ok  out  1  document well-formed
- res_err  out  4  error code, 0 when ok
- res_pos  out  POS_W  0-based offset of first offending byte
- res_max_depth  out  DEPTH_W  deepest nesting reached

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: in_ready=1, res_valid=0, res_ok=0, res_err=0, res_pos=0, res_max_depth=0; FSM=VALUE, depth=0, pos=0.
- Reset mid-document aborts it silently; no result is produced.
- in_ready = !res_valid. A pending result blocks the next document.
- res_valid rises the cycle after the `last` byte is accepted and holds, with stable fields, until res_ready. It then clears, and per-document state has already been re-armed.
- Whitespace is SP, TAB, LF, CR. It is legal in VALUE and AFTER states; inside strings it is literal.
- FSM states: VALUE, STR, ESC, UHEX, LIT, NUM, AFTER, DRAIN.
- VALUE:
  - `{` / `[` push type bit (1=object) and depth++. Pushing at depth==MAX_DEPTH is err 3.
  - `}` / `]` pop. A type mismatch or depth==0 is err 2.
  - `"` → STR.
  - `t`/`f`/`n` → LIT with expected string "true"/"false"/"null" and index 1.
  - `-` or digit → NUM.
  - `,` and `:` are legal only at depth>0, else err 1.
  - Any other byte is err 1.
- STR:
  - `"` ends the string.
  - `\` → ESC.
  - A byte <0x20 is err 8.
- ESC:
  - One of `"\/bfnrt` → STR.
  - `u` → UHEX with count 0.
  - Anything else is err 4.
- UHEX: 4 hex digits (either case), then → STR. A non-hex byte is err 4.
- LIT: each byte must equal the expected character, else err 5. After the final character, the next byte must be a delimiter (whitespace , ] }) or the document must end, else err 5. The delimiter is processed in the same cycle.
- NUM: continues on [0-9.eE+-]. A delimiter ends it and is processed in the same cycle. Any other byte is err 1. No numeric grammar is checked beyond the character set.
- End of a value: if depth==0 after it completes (a string, literal, number or closing bracket), go to AFTER; otherwise stay in VALUE.
- AFTER: whitespace only. Any other byte is err 7.
- First error: latch err/pos and go to DRAIN. DRAIN accepts and ignores bytes until `last`. Later errors are never reported.
- Unexpected end is err 6, with res_pos = byte count. It applies when `last` arrives with:
  - state STR, ESC or UHEX; or
  - depth>0; or
  - an incomplete literal; or
  - no value seen.
- A literal or number terminated by `last` is OK.
- Simultaneous error and `last` on the same byte: report that byte's error.
- pos increments per accepted byte and saturates. res_pos uses the pre-increment value.
- res_max_depth tracks the running maximum of depth, including at error.
- Error codes: 0 none, 1 unexpected char, 2 bracket mismatch, 3 depth overflow, 4 bad escape, 5 bad literal, 6 unexpected end, 7 trailing content, 8 control char in string.

Test Plan:
- `{"a":[1,true,null]}`, last on `}` → res_valid one cycle later; ok=1, err=0, max_depth=2.
- `[1,2}` → err=2, pos=4. `]` alone → err=2, pos=0.
- MAX_DEPTH=4, `[[[[[]]]]]` → err=3, pos=4. Bytes after the error are drained; exactly one result is produced.
- `"\q"` → err=4, pos=2. `"\u12G4"` → err=4, pos=5. `"a<0x0A>"` → err=8, pos=2.
- `[tru]` → err=5, pos=4. `{"a":1} x` → err=7, pos=8. `["abc` → err=6, pos=5. `-12` → ok=1.
- Hold res_ready=0 for 5 cycles → in_ready=0 and fields stable; release → next document accepted. Reset asserted mid-document → all outputs at reset values; res_valid never rises.
